// File: rtl/seg_sched_pkg.sv
// Shared definitions for the display scheduler: state encoding and the blank frame
// that is sent when nobody wants the display.
package seg_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DWELL
    } state_t;

    localparam logic [7:0]  SEG_BLANK_EN    = 8'hFF;
    localparam logic [31:0] SEG_BLANK_NUM   = 32'h0000_0000;
    localparam logic [7:0]  SEG_BLANK_POINT = 8'h00;

endpackage

// File: rtl/seg_rr_picker.sv
// Combinational round-robin picker: first set req bit after index 'last', wrapping,
// so the previous winner is considered last.
module seg_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-slices the shared 8-digit serial display between N_REQ requesters, one frame each.
// Define SEG_SCHED_PRIORITY_EN to make requester 0 preemptive (wins LOAD, cuts DWELL short).
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DWELL_CYCLES   = 262144,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_nums,
    input  logic [8*N_REQ-1:0]   req_ens,
    input  logic [8*N_REQ-1:0]   req_points,
    input  logic                 drv_finish,
    output logic                 drv_start,
    output logic [7:0]           drv_en,
    output logic [31:0]          drv_num,
    output logic [7:0]           drv_point,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t           state, next_state;
    logic [IDX_W-1:0] last, pick_idx, sel_idx;
    logic [N_REQ-1:0] pick_onehot, sel_onehot;
    logic             pick_valid;
    logic             preempt;
    logic [TO_W-1:0]  to_cnt;
    logic [DW_W-1:0]  dw_cnt;
    logic             to_hit, dw_hit, owner_gone;

    seg_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req    (req),
        .last   (last),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        sel_idx    = pick_idx;
        sel_onehot = pick_onehot;
        preempt    = 1'b0;
`ifdef SEG_SCHED_PRIORITY_EN
        if (req[0]) begin
            sel_idx    = '0;
            sel_onehot = N_REQ'(1);
        end
        preempt = req[0] && !grant[0];
`endif
    end

    // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1,
    // i.e. TIMEOUT_CYCLES cycles after the start pulse.
    assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));
    assign dw_hit     = (dw_cnt == DW_W'(DWELL_CYCLES - 1));
    assign owner_gone = ((req & grant) == '0);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (|req) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_START;
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (drv_finish)  next_state = (grant == '0) ? ST_IDLE : ST_DWELL;
                else if (to_hit) next_state = ST_LOAD;
            end
            ST_DWELL: if (dw_hit || owner_gone || preempt) next_state = ST_LOAD;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last        <= IDX_W'(N_REQ - 1);
            to_cnt      <= '0;
            dw_cnt      <= '0;
            drv_start   <= 1'b0;
            drv_en      <= SEG_BLANK_EN;
            drv_num     <= SEG_BLANK_NUM;
            drv_point   <= SEG_BLANK_POINT;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= next_state;
            drv_start <= (next_state == ST_START);
            busy      <= (next_state != ST_IDLE);
            case (state)
                ST_LOAD: begin
                    if (pick_valid) begin
                        drv_num   <= req_nums[32*int'(sel_idx) +: 32];
                        drv_en    <= req_ens[8*int'(sel_idx) +: 8];
                        drv_point <= req_points[8*int'(sel_idx) +: 8];
                        grant     <= sel_onehot;
                        last      <= sel_idx;
                    end else begin
                        drv_num   <= SEG_BLANK_NUM;
                        drv_en    <= SEG_BLANK_EN;
                        drv_point <= SEG_BLANK_POINT;
                        grant     <= '0;
                    end
                end
                ST_START: to_cnt <= '0;
                ST_WAIT: begin
                    if (drv_finish) begin
                        dw_cnt <= '0;
                    end else begin
                        if (to_hit) timeout_err <= 1'b1;
                        if (to_cnt != TO_W'(TIMEOUT_CYCLES - 1)) to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DWELL: if (!dw_hit) dw_cnt <= dw_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (N_REQ=4, DWELL_CYCLES=8, TIMEOUT_CYCLES=16).
// Expected timings differ where SEG_SCHED_PRIORITY_EN is defined.
module tb_seg_display_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_nums;
    logic [31:0]  req_ens;
    logic [31:0]  req_points;
    logic         drv_finish;
    logic         drv_start;
    logic [7:0]   drv_en;
    logic [31:0]  drv_num;
    logic [7:0]   drv_point;
    logic [3:0]   grant;
    logic         busy;
    logic         timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int gap;
    int starts_seen;
    int busy_seen;

    seg_display_scheduler #(
        .N_REQ          (4),
        .DWELL_CYCLES   (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_nums    (req_nums),
        .req_ens     (req_ens),
        .req_points  (req_points),
        .drv_finish  (drv_finish),
        .drv_start   (drv_start),
        .drv_en      (drv_en),
        .drv_num     (drv_num),
        .drv_point   (drv_point),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] g, input logic [31:0] num,
                               input logic [7:0] en, input logic [7:0] pt);
        check_output({tag, "_grant"}, 64'(grant), 64'(g));
        check_output({tag, "_num"}, 64'(drv_num), 64'(num));
        check_output({tag, "_en"}, 64'(drv_en), 64'(en));
        check_output({tag, "_point"}, 64'(drv_point), 64'(pt));
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_start"}, 64'(drv_start), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_terr"}, 64'(timeout_err), 64'd0);
        check_frame(tag, 4'b0000, 32'h0, 8'hFF, 8'h00);
    endtask

    // Ticks until drv_start is seen; returns the tick count, or -1 if the bound expires.
    task automatic wait_for_start(input int limit, output int cycles);
        bit found = 1'b0;
        cycles = 0;
        while (cycles < limit && !found) begin
            tick();
            cycles++;
            if (drv_start) found = 1'b1;
        end
        if (!found) cycles = -1;
    endtask

    task automatic drive_finish(input int delay);
        repeat (delay - 1) tick();
        drv_finish = 1'b1;
        tick();
        drv_finish = 1'b0;
    endtask

    initial begin
        int err_ticks;
        rst        = 1'b1;
        req        = 4'b0000;
        drv_finish = 1'b0;
        req_nums   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_ens    = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        req_points = {8'h08, 8'h04, 8'h02, 8'h01};

        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;

        starts_seen = 0;
        busy_seen   = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (drv_start) starts_seen++;
            if (busy) busy_seen++;
        end
        check_output("idle_starts", 64'(starts_seen), 64'd0);
        check_output("idle_busy", 64'(busy_seen), 64'd0);
        check_output("idle_en", 64'(drv_en), 64'hFF);

        $display("[TB] round robin over req=0101");
        req = 4'b0101;
        tick();
        check_output("load_busy", 64'(busy), 64'd1);
        check_output("load_nostart", 64'(drv_start), 64'd0);
        tick();
        check_output("first_start", 64'(drv_start), 64'd1);
        check_frame("frame0", 4'b0001, 32'h1111_1111, 8'hF0, 8'h01);
        drive_finish(5);
        check_output("dwell_busy", 64'(busy), 64'd1);
        wait_for_start(40, gap);
        check_output("rr_gap1", 64'(gap), 64'd9);
        check_frame("frame2", 4'b0100, 32'h3333_3333, 8'hF2, 8'h04);
        drive_finish(5);
        wait_for_start(40, gap);
        check_output("rr_gap2", 64'(gap), 64'd9);
        check_frame("frame0b", 4'b0001, 32'h1111_1111, 8'hF0, 8'h01);

        $display("[TB] owner drops in dwell, blank frame");
        drive_finish(5);
        repeat (3) tick();
        req = 4'b0000;
        wait_for_start(40, gap);
        check_output("blank_gap", 64'(gap), 64'd2);
        check_frame("blank", 4'b0000, 32'h0, 8'hFF, 8'h00);
        drive_finish(5);
        check_output("blank_idle_busy", 64'(busy), 64'd0);
        tick();
        check_output("blank_hold_en", 64'(drv_en), 64'hFF);

        $display("[TB] driver timeout");
        req = 4'b0110;
        wait_for_start(40, gap);
        check_output("to_gap", 64'(gap), 64'd2);
        check_frame("frame1", 4'b0010, 32'h2222_2222, 8'hF1, 8'h02);
        err_ticks = 0;
        while (!timeout_err && err_ticks < 40) begin
            tick();
            err_ticks++;
        end
        check_output("to_latency", 64'(err_ticks), 64'd16);
        tick();
        check_output("to_restart", 64'(drv_start), 64'd1);
        check_frame("to_rotate", 4'b0100, 32'h3333_3333, 8'hF2, 8'h04);
        drive_finish(5);
        check_output("to_sticky", 64'(timeout_err), 64'd1);

        $display("[TB] requester 0 rises during dwell");
        req = 4'b0111;
        wait_for_start(40, gap);
`ifdef SEG_SCHED_PRIORITY_EN
        check_output("pre_dwell_gap", 64'(gap), 64'd2);
`else
        check_output("pre_dwell_gap", 64'(gap), 64'd9);
`endif
        check_output("pre_dwell_grant", 64'(grant), 64'b0001);

        req = 4'b0100;
        drive_finish(5);
        wait_for_start(40, gap);
        check_output("drop0_gap", 64'(gap), 64'd2);
        check_output("drop0_grant", 64'(grant), 64'b0100);

        $display("[TB] requester 0 rises during wait");
        req = 4'b0101;
        repeat (3) tick();
        check_output("wait_nostart", 64'(drv_start), 64'd0);
        check_output("wait_grant", 64'(grant), 64'b0100);
        drive_finish(2);
        wait_for_start(40, gap);
`ifdef SEG_SCHED_PRIORITY_EN
        check_output("pre_wait_gap", 64'(gap), 64'd2);
`else
        check_output("pre_wait_gap", 64'(gap), 64'd9);
`endif
        check_output("pre_wait_grant", 64'(grant), 64'b0001);
        check_output("terr_still", 64'(timeout_err), 64'd1);

        $display("[TB] reset during wait");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_reset_state("wait_reset");
        rst = 1'b0;
        req = 4'b1111;
        wait_for_start(40, gap);
        check_output("post_reset_gap", 64'(gap), 64'd2);
        check_frame("post_reset", 4'b0001, 32'h1111_1111, 8'hF0, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-slicing scheduler that shares the single 8-digit serial hex display between up to `N_REQ` requesters. It selects one requester per refresh frame round-robin and latches that requester's digits, enables and points. It pulses `start` to the serial segment driver (`SEG_DRV`), waits for the driver's `finish`, then holds the frame for a dwell period before rotating. It replaces the free-running `clkdiv`-bit start of the existing display wrapper, sitting between application logic and `SEG_DRV`.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `DWELL_CYCLES`, 262144 — clock cycles a frame stays displayed after `finish`, ≥1.
- `TIMEOUT_CYCLES`, 4096 — maximum cycles to wait for `drv_finish` after `start`, ≥2.
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `req` in N_REQ — bit i high: requester i wants display time.
- `req_nums` in 32·N_REQ — requester i's hex digits at bits [32i+31:32i].
- `req_ens` in 8·N_REQ — requester i's digit enables, 0 = digit on.
- `req_points` in 8·N_REQ — requester i's decimal points, 1 = lit.
- `drv_finish` in 1 — one-cycle pulse from `SEG_DRV` when the serial shift completes.
- `drv_start` out 1 — one-cycle start pulse to `SEG_DRV`.
- `drv_en` out 8 — latched enables to `SEG_DRV`.
- `drv_num` out 32 — latched digits to `SEG_DRV`.
- `drv_point` out 8 — latched points to `SEG_DRV`.
- `grant` out N_REQ — one-hot owner of the displayed frame; all-zero when blank.
- `busy` out 1 — high in every state except IDLE.
- `timeout_err` out 1 — sticky; set on a `drv_finish` timeout, cleared only by `rst`.

## Operation
- States: IDLE, LOAD, START, WAIT, DWELL.
- **IDLE:**
  - If any `req` bit is set → LOAD.
  - Otherwise stay; the outputs hold the last frame.
- **LOAD:**
  - Picker chooses the first set `req` bit searching from `last+1` modulo N_REQ, wrapping. `last` is the previously granted index; it resets to N_REQ−1, so requester 0 is first after reset.
  - Latches that requester's slices into `drv_num/en/point`, updates `grant` and `last` → START.
  - If no `req` bit is set at LOAD: latches the blank frame (`en`=8'hFF, `num`=0, `point`=0) and `grant`=0 → START. This performs one blank refresh, after which the scheduler returns to IDLE.
- **START:** `drv_start`=1 for exactly this cycle; clears the timeout counter → WAIT.
- **WAIT:**
  - On `drv_finish` → DWELL with the dwell counter cleared. For a blank frame → IDLE instead.
  - If the counter reaches TIMEOUT_CYCLES−1 without `finish`: set `timeout_err` → LOAD. The same requester is not retried; rotation continues.
- **DWELL:** count to DWELL_CYCLES−1, then → LOAD. Leave DWELL early (→ LOAD next cycle) if the granted requester's `req` bit drops.
- Latched frame data is stable from LOAD until the next LOAD; requester inputs may change freely meanwhile.
- A `drv_finish` pulse outside WAIT is ignored.
- Counters are sized `$clog2` of their parameter and saturate at terminal count; they never wrap.

## Timing
- All outputs are registered.
- Reset values: `drv_start`=0, `drv_en`=8'hFF, `drv_num`=0, `drv_point`=0, `grant`=0, `busy`=0, `timeout_err`=0; state = IDLE.
- `req` rising in IDLE at edge n:
  - LOAD at n+1.
  - Outputs valid and `drv_start` high at n+2.
  - WAIT from n+3.
- `drv_finish` at edge m → DWELL at m+1 → LOAD at m+1+DWELL_CYCLES → next `drv_start` one cycle later.
- `rst` asserted in any state takes effect at the next edge. `drv_start` is never high in the cycle after reset.
- `req` and `drv_finish` changing in the same cycle: `drv_finish` is processed first (WAIT → DWELL); the dropped `req` then ends DWELL on the following cycle.

## Configuration
- `SEG_SCHED_PRIORITY_EN` defined:
  - Requester 0 is preemptive. In LOAD, `req[0]` wins regardless of `last`.
  - In DWELL, `req[0]` rising while another requester is granted ends the dwell at the next edge → LOAD.
  - Requester 0 never preempts START or WAIT, so a serial frame is never cut.
- Undefined: pure round-robin, with no preemption.

## Structure
- Shared package `seg_sched_pkg`: state encoding, blank-frame constants (`SEG_BLANK_EN`=8'hFF, `SEG_BLANK_NUM`=0, `SEG_BLANK_POINT`=0).
- Sub-module `seg_rr_picker`: combinational round-robin picker. Inputs `req` and `last`; outputs `valid`, index, one-hot. The priority override is applied in the parent.

## Test plan
- Reset, then `req`=4'b0000 for 100 cycles → outputs stay at reset values, `busy`=0, no `drv_start`.
- `req`=4'b0101, `finish` returned 5 cycles after each start, DWELL_CYCLES=8 → `grant` sequence 0001, 0100, 0001, …; `drv_num` matches each slice; `drv_start` at the fixed period.
- Granted requester drops `req` mid-DWELL, all `req` now 0 → one blank frame (`drv_en`=8'hFF, `grant`=0) is sent, then IDLE with `busy`=0.
- `drv_finish` withheld, TIMEOUT_CYCLES=16 → `timeout_err` is set 16 cycles after start, rotation moves to the next requester, and `timeout_err` stays 1 until `rst`.
- With `SEG_SCHED_PRIORITY_EN`: requester 2 in DWELL, `req[0]` rises → LOAD next cycle, `grant`=0001. With `req[0]` rising in WAIT → granted only after `drv_finish`.
- `rst` pulsed in WAIT → next cycle all outputs at reset values; the first post-reset grant goes to requester 0.
